// File: rtl/cable_link.sv
// cable_link: two independent registered valid/ready channels (fwd, rev), each
// STAGES deep and WIDTH bits wide, with a loopback mode and a forward transfer counter.
//
// Parameters:
//   WIDTH  - data bits per word per channel (1..32)
//   STAGES - register stages per channel (1..8)
//   CNT_W  - width of the wrap-around forward transfer counter
//
// Ports:
//   clk, reset_n                        - clock, asynchronous active-low reset
//   fwd_in_data/valid/ready             - forward source interface
//   fwd_out_data/valid/ready            - forward sink interface
//   rev_in_data/valid/ready             - reverse source interface
//   rev_out_data/valid/ready            - reverse sink interface
//   loopback                            - 1: forward output stage feeds the reverse input
//   xfer_count                          - words that left the forward output stage
//
// Optional feature, macro CABLE_LINK_PARITY_EN:
//   adds fwd_in_par, rev_in_par (even parity over {par,data}) and a sticky
//   parity_err output. Parity travels alongside the data in every stage.

// One elastic channel: STAGES registers with a combinational ready chain.
module cable_link_pipe #(
  parameter int DW     = 8,
  parameter int STAGES = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready
);

  logic [STAGES-1:0] v_r;
  logic [DW-1:0]     d_r [STAGES];
  logic [STAGES-1:0] rdy_s;
  logic [STAGES-1:0] up_v_s;
  logic [DW-1:0]     up_d_s [STAGES];
  logic              acc_s;

  // Ready chain from the sink backwards: a stage may load when it is empty
  // or any stage downstream of it is empty or the sink is taking a word.
  always_comb begin
    acc_s = out_ready;
    rdy_s = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      acc_s    = acc_s | ~v_r[k];
      rdy_s[k] = acc_s;
    end
    up_v_s[0] = in_valid;
    up_d_s[0] = in_data;
    for (int k = 1; k < STAGES; k++) begin
      up_v_s[k] = v_r[k-1];
      up_d_s[k] = d_r[k-1];
    end
  end

  // Stage registers: a ready stage takes whatever its upstream neighbour holds.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_r <= '0;
      for (int k = 0; k < STAGES; k++) begin
        d_r[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (rdy_s[k]) begin
          v_r[k] <= up_v_s[k];
          if (up_v_s[k]) begin
            d_r[k] <= up_d_s[k];
          end
        end
      end
    end
  end

  assign in_ready  = rdy_s[0];
  assign out_valid = v_r[STAGES-1];
  assign out_data  = d_r[STAGES-1];

endmodule

module cable_link #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] fwd_in_data,
  input  logic             fwd_in_valid,
  output logic             fwd_in_ready,
  output logic [WIDTH-1:0] fwd_out_data,
  output logic             fwd_out_valid,
  input  logic             fwd_out_ready,
  input  logic [WIDTH-1:0] rev_in_data,
  input  logic             rev_in_valid,
  output logic             rev_in_ready,
  output logic [WIDTH-1:0] rev_out_data,
  output logic             rev_out_valid,
  input  logic             rev_out_ready,
  input  logic             loopback,
  output logic [CNT_W-1:0] xfer_count
`ifdef CABLE_LINK_PARITY_EN
  ,
  input  logic             fwd_in_par,
  input  logic             rev_in_par,
  output logic             parity_err
`endif
);

`ifdef CABLE_LINK_PARITY_EN
  localparam int DW = WIDTH + 1;
`else
  localparam int DW = WIDTH;
`endif

  logic [DW-1:0] fwd_in_w_s;
  logic [DW-1:0] fwd_out_w_s;
  logic          fwd_v_s;
  logic          fwd_sink_ready_s;
  logic          fwd_fire_s;
  logic [DW-1:0] rev_src_w_s;
  logic [DW-1:0] rev_in_w_s;
  logic          rev_in_v_s;
  logic          rev_rdy0_s;
  logic [DW-1:0] rev_out_w_s;

`ifdef CABLE_LINK_PARITY_EN
  assign fwd_in_w_s  = {fwd_in_par, fwd_in_data};
  assign rev_src_w_s = {rev_in_par, rev_in_data};
`else
  assign fwd_in_w_s  = fwd_in_data;
  assign rev_src_w_s = rev_in_data;
`endif

  cable_link_pipe #(.DW(DW), .STAGES(STAGES)) u_fwd (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (fwd_in_w_s),
    .in_valid  (fwd_in_valid),
    .in_ready  (fwd_in_ready),
    .out_data  (fwd_out_w_s),
    .out_valid (fwd_v_s),
    .out_ready (fwd_sink_ready_s)
  );

  cable_link_pipe #(.DW(DW), .STAGES(STAGES)) u_rev (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (rev_in_w_s),
    .in_valid  (rev_in_v_s),
    .in_ready  (rev_rdy0_s),
    .out_data  (rev_out_w_s),
    .out_valid (rev_out_valid),
    .out_ready (rev_out_ready)
  );

  // Loopback routing: the forward output stage hands its word straight to
  // the reverse input stage, hiding the external fwd sink and rev source.
  always_comb begin
    if (loopback) begin
      fwd_sink_ready_s = rev_rdy0_s;
      rev_in_w_s       = fwd_out_w_s;
      rev_in_v_s       = fwd_v_s;
      rev_in_ready     = 1'b0;
      fwd_out_valid    = 1'b0;
    end else begin
      fwd_sink_ready_s = fwd_out_ready;
      rev_in_w_s       = rev_src_w_s;
      rev_in_v_s       = rev_in_valid;
      rev_in_ready     = rev_rdy0_s;
      fwd_out_valid    = fwd_v_s;
    end
  end

  assign fwd_fire_s   = fwd_v_s & fwd_sink_ready_s;
  assign fwd_out_data = fwd_out_w_s[WIDTH-1:0];
  assign rev_out_data = rev_out_w_s[WIDTH-1:0];

  // Forward transfer counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      xfer_count <= '0;
    end else if (fwd_fire_s) begin
      xfer_count <= xfer_count + CNT_W'(1);
    end else begin
      xfer_count <= xfer_count;
    end
  end

`ifdef CABLE_LINK_PARITY_EN
  logic rev_fire_s;

  // Even parity over {par,data}: any odd reduction is an error.
  function automatic logic par_bad(input logic [DW-1:0] w);
    return ^w;
  endfunction

  assign rev_fire_s = rev_out_valid & rev_out_ready;

  // Sticky parity error, checked on every word leaving either output stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      parity_err <= 1'b0;
    end else if ((fwd_fire_s && par_bad(fwd_out_w_s)) ||
                 (rev_fire_s && par_bad(rev_out_w_s))) begin
      parity_err <= 1'b1;
    end else begin
      parity_err <= parity_err;
    end
  end
`endif

endmodule

// File: tb/tb_cable_link.sv
// Directed scoreboard testbench for cable_link (WIDTH=8, STAGES=3, CNT_W=4).
module tb_cable_link;
  localparam int WIDTH  = 8;
  localparam int STAGES = 3;
  localparam int CNT_W  = 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic [WIDTH-1:0] fwd_in_data = '0;
  logic             fwd_in_valid = 1'b0;
  logic             fwd_in_ready;
  logic [WIDTH-1:0] fwd_out_data;
  logic             fwd_out_valid;
  logic             fwd_out_ready = 1'b0;
  logic [WIDTH-1:0] rev_in_data = '0;
  logic             rev_in_valid = 1'b0;
  logic             rev_in_ready;
  logic [WIDTH-1:0] rev_out_data;
  logic             rev_out_valid;
  logic             rev_out_ready = 1'b0;
  logic             loopback = 1'b0;
  logic [CNT_W-1:0] xfer_count;
`ifdef CABLE_LINK_PARITY_EN
  logic             fwd_in_par = 1'b0;
  logic             rev_in_par = 1'b0;
  logic             parity_err;
`endif

  cable_link #(.WIDTH(WIDTH), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .fwd_in_data   (fwd_in_data),
    .fwd_in_valid  (fwd_in_valid),
    .fwd_in_ready  (fwd_in_ready),
    .fwd_out_data  (fwd_out_data),
    .fwd_out_valid (fwd_out_valid),
    .fwd_out_ready (fwd_out_ready),
    .rev_in_data   (rev_in_data),
    .rev_in_valid  (rev_in_valid),
    .rev_in_ready  (rev_in_ready),
    .rev_out_data  (rev_out_data),
    .rev_out_valid (rev_out_valid),
    .rev_out_ready (rev_out_ready),
    .loopback      (loopback),
    .xfer_count    (xfer_count)
`ifdef CABLE_LINK_PARITY_EN
    ,
    .fwd_in_par    (fwd_in_par),
    .rev_in_par    (rev_in_par),
    .parity_err    (parity_err)
`endif
  );

  always #5 clk = ~clk;

  // Rising-edge counter used to measure latency.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    int         acc;
    int         lat;
  } sb_t;

  sb_t fwd_q[$];
  sb_t rev_q[$];
  sb_t mon_e;
  int  pass_cnt = 0;
  int  check_cnt = 0;
  bit  lb = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Output monitor: a transfer happens at the next rising edge when valid&ready.
  always @(negedge clk) begin
    if (reset_n) begin
      if (fwd_out_valid === 1'b1 && fwd_out_ready === 1'b1) begin
        if (fwd_q.size() == 0) begin
          chk("fwd_unexpected_word", 32'(fwd_q.size()), 32'd1);
        end else begin
          mon_e = fwd_q.pop_front();
          chk("fwd_data", 32'(fwd_out_data), 32'(mon_e.data));
          if (mon_e.lat != 0) chk("fwd_latency", 32'(cyc + 1 - mon_e.acc), 32'(mon_e.lat));
        end
      end
      if (rev_out_valid === 1'b1 && rev_out_ready === 1'b1) begin
        if (rev_q.size() == 0) begin
          chk("rev_unexpected_word", 32'(rev_q.size()), 32'd1);
        end else begin
          mon_e = rev_q.pop_front();
          chk("rev_data", 32'(rev_out_data), 32'(mon_e.data));
          if (mon_e.lat != 0) chk("rev_latency", 32'(cyc + 1 - mon_e.acc), 32'(mon_e.lat));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_fwd(input logic [7:0] d, input int lat, input logic flip);
    fwd_in_data  = d;
    fwd_in_valid = 1'b1;
`ifdef CABLE_LINK_PARITY_EN
    fwd_in_par = (^d) ^ flip;
`endif
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (fwd_in_ready === 1'b1) begin
        if (lb) rev_q.push_back('{d, cyc + 1, lat});
        else    fwd_q.push_back('{d, cyc + 1, lat});
        tick();
        fwd_in_valid = 1'b0;
        return;
      end
      tick();
    end
    chk("fwd_accept_timeout", 32'(fwd_in_ready), 32'd1);
    fwd_in_valid = 1'b0;
  endtask

  task automatic send_rev(input logic [7:0] d, input int lat);
    rev_in_data  = d;
    rev_in_valid = 1'b1;
`ifdef CABLE_LINK_PARITY_EN
    rev_in_par = ^d;
`endif
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rev_in_ready === 1'b1) begin
        rev_q.push_back('{d, cyc + 1, lat});
        tick();
        rev_in_valid = 1'b0;
        return;
      end
      tick();
    end
    chk("rev_accept_timeout", 32'(rev_in_ready), 32'd1);
    rev_in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 100; i++) begin
      if (fwd_q.size() == 0 && rev_q.size() == 0) return;
      tick();
    end
    chk({tag, "_drain_timeout"}, 32'(fwd_q.size() + rev_q.size()), 32'd0);
  endtask

  initial begin
    // Reset: outputs clear asynchronously.
    #1 reset_n = 1'b0;
    #1;
    chk("rst_fwd_out_valid", 32'(fwd_out_valid), 32'd0);
    chk("rst_rev_out_valid", 32'(rev_out_valid), 32'd0);
    chk("rst_fwd_out_data", 32'(fwd_out_data), 32'd0);
    chk("rst_xfer_count", 32'(xfer_count), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    chk("rst_fwd_in_ready", 32'(fwd_in_ready), 32'd1);
    chk("rst_rev_in_ready", 32'(rev_in_ready), 32'd1);

    // Back-to-back forward stream with sink ready: latency STAGES, 1 word/cycle.
    fwd_out_ready = 1'b1;
    rev_out_ready = 1'b1;
    send_fwd(8'h11, STAGES, 1'b0);
    send_fwd(8'h22, STAGES, 1'b0);
    send_fwd(8'h33, STAGES, 1'b0);
    drain("stream");
    chk("stream_xfer_count", 32'(xfer_count), 32'd3);

    // Backpressure: capacity is exactly STAGES words.
    fwd_out_ready = 1'b0;
    send_fwd(8'hA0, 0, 1'b0);
    send_fwd(8'hA1, 0, 1'b0);
    send_fwd(8'hA2, 0, 1'b0);
    fwd_in_data  = 8'hA3;
    fwd_in_valid = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_full", 32'(fwd_in_ready), 32'd0);
    tick();
    @(negedge clk);
    chk("bp_in_ready_still_full", 32'(fwd_in_ready), 32'd0);
    chk("bp_head_word", 32'(fwd_out_data), 32'hA0);
    tick();
    fwd_out_ready = 1'b1;
    send_fwd(8'hA3, 0, 1'b0);
    send_fwd(8'hA4, 0, 1'b0);
    drain("bp");
    chk("bp_xfer_count", 32'(xfer_count), 32'd8);

    // Loopback: fwd stream routed into rev, external fwd sink / rev source hidden.
    loopback      = 1'b1;
    lb            = 1'b1;
    fwd_out_ready = 1'b0;
    rev_in_data   = 8'hEE;
    rev_in_valid  = 1'b1;
    @(negedge clk);
    chk("lb_rev_in_ready", 32'(rev_in_ready), 32'd0);
    tick();
    send_fwd(8'h5A, 2 * STAGES, 1'b0);
    for (int i = 0; i < STAGES; i++) begin
      @(negedge clk);
      chk("lb_fwd_out_valid", 32'(fwd_out_valid), 32'd0);
    end
    tick();
    drain("lb");
    chk("lb_xfer_count", 32'(xfer_count), 32'd9);
    loopback      = 1'b0;
    lb            = 1'b0;
    rev_in_valid  = 1'b0;
    fwd_out_ready = 1'b1;
    tick();

    // Reverse channel on its own.
    send_rev(8'hC3, STAGES);
    send_rev(8'h3C, STAGES);
    drain("rev");
    chk("rev_xfer_count_unchanged", 32'(xfer_count), 32'd9);

    // Reset between edges with words in flight.
    rev_out_ready = 1'b0;
    fwd_out_ready = 1'b0;
    send_rev(8'h81, 0);
    send_fwd(8'h91, 0, 1'b0);
    send_fwd(8'h92, 0, 1'b0);
    tick();
    tick();
    chk("midrst_fwd_valid_before", 32'(fwd_out_valid), 32'd1);
    chk("midrst_rev_valid_before", 32'(rev_out_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_fwd_out_valid", 32'(fwd_out_valid), 32'd0);
    chk("midrst_rev_out_valid", 32'(rev_out_valid), 32'd0);
    chk("midrst_xfer_count", 32'(xfer_count), 32'd0);
    fwd_q.delete();
    rev_q.delete();
    tick();
    reset_n       = 1'b1;
    fwd_out_ready = 1'b1;
    rev_out_ready = 1'b1;

    // Counter wrap with CNT_W=4: 15, then 0, then 1.
    for (int i = 0; i < 15; i++) send_fwd(8'(8'h40 + i), STAGES, 1'b0);
    drain("wrap15");
    chk("wrap_count_15", 32'(xfer_count), 32'd15);
    send_fwd(8'h77, STAGES, 1'b0);
    drain("wrap16");
    chk("wrap_count_0", 32'(xfer_count), 32'd0);
    send_fwd(8'h78, STAGES, 1'b0);
    drain("wrap17");
    chk("wrap_count_1", 32'(xfer_count), 32'd1);

`ifdef CABLE_LINK_PARITY_EN
    // Sticky parity error.
    chk("par_clean_so_far", 32'(parity_err), 32'd0);
    send_fwd(8'h03, STAGES, 1'b0);
    drain("par_ok");
    chk("par_after_good", 32'(parity_err), 32'd0);
    send_fwd(8'h01, STAGES, 1'b1);
    drain("par_bad");
    chk("par_after_bad", 32'(parity_err), 32'd1);
    send_fwd(8'h03, STAGES, 1'b0);
    drain("par_sticky");
    tick();
    chk("par_sticky", 32'(parity_err), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("par_reset", 32'(parity_err), 32'd0);
    tick();
    reset_n = 1'b1;
`endif

    tick();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
